// File: rtl/mc_bus_pkg.sv
// Shared types and constants for the multi-channel bus initiator.
package mc_bus_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int CH_MSB  = 5;
    localparam int CH_LSB  = 3;
    localparam int OFF_MSB = 2;
    localparam int OFF_LSB = 0;

    localparam logic FPA_RW_READ  = 1'b1;
    localparam logic FPA_RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } mc_state_e;

endpackage

// File: rtl/mc_bus_initiator.sv
// Single-transaction bus initiator: setup / strobe / hold sequencing with a 4-bit down-counter.
// Optional MC_BUS_TURNAROUND_EN adds one idle TURN cycle after HOLD.
//
// state  | meaning
// IDLE   | ready for a request, bus idle
// SETUP  | address and chip-select driven, no strobe
// STROBE | read or write strobe active
// HOLD   | strobe released, address/data/chip-select held
// TURN   | extra bus-idle cycle before IDLE (turnaround build only)
module mc_bus_initiator
    import mc_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mc_ba,
    output logic              mc_cs3_n,
    output logic              fpa_rw,
    output logic              mc_re_n,
    output logic [DATA_W-1:0] mc_bd_o,
    output logic              mc_bd_oe,
    input  logic [DATA_W-1:0] mc_bd_i
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    mc_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cap_d       = cap_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    cap_d   = mc_bd_i;
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? '0 : cap_q;
                    cnt_d       = 4'd0;
`ifdef MC_BUS_TURNAROUND_EN
                    state_d     = ST_TURN;
`else
                    state_d     = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic bus_active;
    logic strobe;

    always_comb begin
        bus_active = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
        strobe     = (state_q == ST_STROBE);
    end

    // Strobes are mutually exclusive by construction: both derive from one latched wr bit.
    assign req_ready = (state_q == ST_IDLE) && !wb_rst_i;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mc_ba     = addr_q;
    assign mc_bd_o   = wdata_q;
    assign mc_cs3_n  = !bus_active;
    assign mc_bd_oe  = bus_active && wr_q;
    assign mc_re_n   = !(strobe && !wr_q);
    assign fpa_rw    = (strobe && wr_q) ? FPA_RW_WRITE : FPA_RW_READ;

endmodule

// File: tb/tb_mc_bus_initiator.sv
// Randomized self-checking bench for mc_bus_initiator; builds with or without MC_BUS_TURNAROUND_EN.
module tb_mc_bus_initiator;

`ifdef MC_BUS_TURNAROUND_EN
    localparam bit TURN = 1'b1;
`else
    localparam bit TURN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0: default timing, dut1: SETUP=2 STROBE=3 HOLD=2
    logic       rv0 = 0, wr0 = 0, rv1 = 0, wr1 = 0;
    logic [5:0] ad0 = 0, ad1 = 0;
    logic [7:0] wd0 = 0, wd1 = 0, bi0 = 0, bi1 = 0;
    logic       rdy0, rspv0, cs0, rw0, re0, oe0;
    logic       rdy1, rspv1, cs1, rw1, re1, oe1;
    logic [7:0] rd0, bdo0, rd1, bdo1;
    logic [5:0] ba0, ba1;

    mc_bus_initiator dut0 (
        .clk(clk), .wb_rst_i(rst), .req_valid(rv0), .req_ready(rdy0), .req_wr(wr0),
        .req_addr(ad0), .req_wdata(wd0), .rsp_valid(rspv0), .rsp_rdata(rd0),
        .mc_ba(ba0), .mc_cs3_n(cs0), .fpa_rw(rw0), .mc_re_n(re0),
        .mc_bd_o(bdo0), .mc_bd_oe(oe0), .mc_bd_i(bi0)
    );

    mc_bus_initiator #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut1 (
        .clk(clk), .wb_rst_i(rst), .req_valid(rv1), .req_ready(rdy1), .req_wr(wr1),
        .req_addr(ad1), .req_wdata(wd1), .rsp_valid(rspv1), .rsp_rdata(rd1),
        .mc_ba(ba1), .mc_cs3_n(cs1), .fpa_rw(rw1), .mc_re_n(re1),
        .mc_bd_o(bdo1), .mc_bd_oe(oe1), .mc_bd_i(bi1)
    );

    typedef struct {
        logic       rdy, rspv, cs, rw, re, oe;
        logic [7:0] rd, bdo;
        logic [5:0] ba;
    } obs_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic w, input logic [5:0] a,
                         input logic [7:0] wd, input logic [7:0] bi);
        if (d == 0) begin
            rv0 = v; wr0 = w; ad0 = a; wd0 = wd; bi0 = bi;
        end else begin
            rv1 = v; wr1 = w; ad1 = a; wd1 = wd; bi1 = bi;
        end
    endtask

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o.rdy = rdy0; o.rspv = rspv0; o.cs = cs0; o.rw = rw0; o.re = re0;
            o.oe = oe0; o.rd = rd0; o.bdo = bdo0; o.ba = ba0;
        end else begin
            o.rdy = rdy1; o.rspv = rspv1; o.cs = cs1; o.rw = rw1; o.re = re1;
            o.oe = oe1; o.rd = rd1; o.bdo = bdo1; o.ba = ba1;
        end
        return o;
    endfunction

    function automatic int setup_of(input int d);  return (d == 0) ? 1 : 2; endfunction
    function automatic int strobe_of(input int d); return (d == 0) ? 2 : 3; endfunction
    function automatic int hold_of(input int d);   return (d == 0) ? 1 : 2; endfunction

    task automatic check_invariants(input obs_t o);
        chk("no_re_and_wr_strobe", 32'(!o.re && !o.rw), 0);
        chk("no_oe_during_read", 32'(o.oe && !o.re), 0);
    endtask

    // One transaction with request fields scrambled while busy; bi_fixed < 0 means random bus data.
    task automatic do_txn(input int d, input logic w, input logic [5:0] a, input logic [7:0] wd,
                          input int bi_fixed);
        int s, t, h, last, waited;
        logic [7:0] bi, cap;
        obs_t o;
        logic in_strobe;
        s = setup_of(d); t = strobe_of(d); h = hold_of(d);
        last = s + t + h + 1;
        cap = 8'h00;
        waited = 0;
        @(negedge clk);
        o = sample(d);
        while (!o.rdy && waited < 50) begin
            @(negedge clk);
            o = sample(d);
            waited++;
        end
        chk("ready_before_accept", 32'(o.rdy), 1);
        if (!o.rdy) return;
        drive(d, 1'b1, w, a, wd, 8'($urandom));
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            #1;
            bi = (bi_fixed >= 0) ? 8'(bi_fixed) : 8'($urandom);
            if (k < last)
                drive(d, 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), bi);
            else
                drive(d, 1'b0, 1'($urandom), 6'($urandom), 8'($urandom), bi);
            if (k == s + t) cap = bi;
            in_strobe = (k > s) && (k <= s + t);
            @(negedge clk);
            o = sample(d);
            check_invariants(o);
            chk("mc_ba", 32'(o.ba), 32'(a));
            chk("mc_bd_o", 32'(o.bdo), 32'(wd));
            if (k < last) begin
                chk("cs_active", 32'(o.cs), 0);
                chk("bd_oe_active", 32'(o.oe), 32'(w));
                chk("re_n_active", 32'(o.re), 32'(!(in_strobe && !w)));
                chk("fpa_rw_active", 32'(o.rw), 32'(!(in_strobe && w)));
                chk("rsp_valid_busy", 32'(o.rspv), 0);
                chk("ready_busy", 32'(o.rdy), 0);
            end else begin
                chk("cs_done", 32'(o.cs), 1);
                chk("bd_oe_done", 32'(o.oe), 0);
                chk("re_n_done", 32'(o.re), 1);
                chk("fpa_rw_done", 32'(o.rw), 1);
                chk("rsp_valid_pulse", 32'(o.rspv), 1);
                chk("rsp_rdata", 32'(o.rd), w ? 32'h0 : 32'(cap));
                chk("ready_at_done", 32'(o.rdy), 32'(!TURN));
            end
            @(posedge clk);
        end
        @(negedge clk);
        o = sample(d);
        chk("rsp_valid_single", 32'(o.rspv), 0);
        chk("rsp_rdata_hold", 32'(o.rd), w ? 32'h0 : 32'(cap));
        chk("cs_idle", 32'(o.cs), 1);
        chk("ready_idle", 32'(o.rdy), 1);
        chk("ba_hold_idle", 32'(o.ba), 32'(a));
    endtask

    task automatic back_to_back;
        int acc;
        obs_t o;
        acc = TURN ? 6 : 5;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 6'h21, 8'h3C, 8'h00);
        @(posedge clk);
        #1 drive(0, 1'b1, 1'b1, 6'h0A, 8'hC3, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            o = sample(0);
            chk("b2b_cs_n", 32'(o.cs), 32'((k == 5) || (TURN && k == 6)));
            chk("b2b_ready", 32'(o.rdy), 32'(k == acc));
            if (k == acc + 1) chk("b2b_second_addr", 32'(o.ba), 32'h0A);
            @(posedge clk);
            if (k == acc) #1 drive(0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00);
        end
        for (int k = 0; k < 12; k++) @(posedge clk);
    endtask

    task automatic reset_mid_strobe;
        obs_t o;
        @(negedge clk);
        while (!rdy0) @(negedge clk);
        drive(0, 1'b1, 1'b0, 6'h2B, 8'h00, 8'h77);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h77);
        @(posedge clk);
        #1;
        chk("rst_pre_re_n", 32'(re0), 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_cs_n", 32'(cs0), 1);
        chk("rst_re_n", 32'(re0), 1);
        chk("rst_bd_oe", 32'(oe0), 0);
        chk("rst_ready", 32'(rdy0), 0);
        chk("rst_rsp_rdata", 32'(rd0), 0);
        chk("rst_ba", 32'(ba0), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(rdy0), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            o = sample(0);
            chk("no_rsp_after_abort", 32'(o.rspv), 0);
        end
    endtask

    initial begin
        obs_t o;
        #2;
        o = sample(0);
        chk("reset_ready", 32'(o.rdy), 0);
        chk("reset_rsp_valid", 32'(o.rspv), 0);
        chk("reset_rsp_rdata", 32'(o.rd), 0);
        chk("reset_ba", 32'(o.ba), 0);
        chk("reset_cs_n", 32'(o.cs), 1);
        chk("reset_fpa_rw", 32'(o.rw), 1);
        chk("reset_re_n", 32'(o.re), 1);
        chk("reset_bd_o", 32'(o.bdo), 0);
        chk("reset_bd_oe", 32'(o.oe), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_txn(0, 1'b1, 6'h13, 8'hA5, -1);
        do_txn(0, 1'b0, 6'h3D, 8'h00, 32'h5A);
        do_txn(1, 1'b0, 6'h07, 8'h11, -1);
        back_to_back();
        for (int i = 0; i < 20; i++) begin
            do_txn(0, 1'($urandom), 6'($urandom), 8'($urandom), -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        for (int i = 0; i < 6; i++)
            do_txn(1, 1'($urandom), 6'($urandom), 8'($urandom), -1);
        reset_mid_strobe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
